// File: rtl/quad_pkg.sv
// Quadrature decoder shared definitions.
//   qdec_state_e : per-channel sequence tracker states
//   LED_UP/LED_DN: bit positions inside a channel's LED pair
//   AB_IDLE      : filtered {A,B} rest pattern (detent)
package quad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CW1,
        S_CW2,
        S_CW3,
        S_CCW1,
        S_CCW2,
        S_CCW3
    } qdec_state_e;

    localparam int LED_UP = 0;
    localparam int LED_DN = 1;

    localparam logic [1:0] AB_IDLE    = 2'b11;
    localparam logic [1:0] LED_PAT_UP = 2'(1 << LED_UP);
    localparam logic [1:0] LED_PAT_DN = 2'(1 << LED_DN);

endpackage

// File: rtl/quad_chan.sv
// One quadrature channel: synchroniser, glitch filter, step FSM,
// position counter, direction LEDs and sticky error flag.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   a, b       : raw encoder phases (asynchronous)
//   clr        : synchronous clear of counter, LEDs and error
//   cnt        : position counter
//   led        : {down, up} indicator of the last step
//   err        : sticky illegal-transition flag (only with QDEC_ERR_EN)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | at detent, filtered {A,B} = 11
// CW1    | up sequence, saw 10
// CW2    | up sequence, saw 00
// CW3    | up sequence, saw 01; return to 11 is an up step
// CCW1   | down sequence, saw 01
// CCW2   | down sequence, saw 00
// CCW3   | down sequence, saw 10; return to 11 is a down step
module quad_chan
    import quad_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int FILT_LEN = 2,
    parameter int WRAP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       led,
    output logic             err
);

    localparam logic [3:0]       FLEN    = 4'(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit 1 carries A, bit 0 carries B.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d;
    logic [1:0]       ab_prev_q;
    logic [3:0]       fcnt_q [2];
    logic [3:0]       fcnt_d [2];
    qdec_state_e      state_q, state_d;
    logic             lock_q, lock_d;
    logic             step_up, step_dn;
    logic [1:0]       chg;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       led_q, led_d;

    // Filter: the accepted bit follows the synchronised bit only after it
    // has differed for FILT_LEN consecutive samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = 4'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] + 4'd1 >= FLEN) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    // The FSM looks at the change of the filtered pair relative to the
    // previous cycle, so a step lands on the counter one clock after the
    // filtered pair reaches 11.
    assign chg = filt_q ^ ab_prev_q;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (chg == 2'b11) begin
            // Both bits moved at once: direction unknown. Park until detent.
            if (filt_q == AB_IDLE) begin
                state_d = S_IDLE;
                lock_d  = 1'b0;
            end else begin
                lock_d  = 1'b1;
            end
        end else if (lock_q) begin
            if (filt_q == AB_IDLE) begin
                state_d = S_IDLE;
                lock_d  = 1'b0;
            end
        end else if (chg != 2'b00) begin
            unique case (state_q)
                S_IDLE: begin
                    if (filt_q == 2'b10)      state_d = S_CW1;
                    else if (filt_q == 2'b01) state_d = S_CCW1;
                end
                S_CW1: begin
                    if (filt_q == 2'b00)         state_d = S_CW2;
                    else if (filt_q == AB_IDLE)  state_d = S_IDLE;
                end
                S_CW2: begin
                    if (filt_q == 2'b01)      state_d = S_CW3;
                    else if (filt_q == 2'b10) state_d = S_CW1;
                end
                S_CW3: begin
                    if (filt_q == AB_IDLE) begin
                        state_d = S_IDLE;
                        step_up = 1'b1;
                    end else if (filt_q == 2'b00) begin
                        state_d = S_CW2;
                    end
                end
                S_CCW1: begin
                    if (filt_q == 2'b00)         state_d = S_CCW2;
                    else if (filt_q == AB_IDLE)  state_d = S_IDLE;
                end
                S_CCW2: begin
                    if (filt_q == 2'b10)      state_d = S_CCW3;
                    else if (filt_q == 2'b01) state_d = S_CCW1;
                end
                S_CCW3: begin
                    if (filt_q == AB_IDLE) begin
                        state_d = S_IDLE;
                        step_dn = 1'b1;
                    end else if (filt_q == 2'b00) begin
                        state_d = S_CCW2;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Clear takes priority over a step landing on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        led_d = led_q;
        if (clr) begin
            cnt_d = '0;
            led_d = '0;
        end else if (step_up) begin
            led_d = LED_PAT_UP;
            if (cnt_q != CNT_MAX || WRAP != 0) cnt_d = cnt_q + CNT_ONE;
        end else if (step_dn) begin
            led_d = LED_PAT_DN;
            if (cnt_q != '0 || WRAP != 0) cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= AB_IDLE;
            ab_prev_q <= AB_IDLE;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= 4'd0;
            state_q   <= S_IDLE;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            led_q     <= '0;
        end else begin
            sync1_q   <= {a, b};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            ab_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
            state_q   <= state_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
        end
    end

    assign cnt = cnt_q;
    assign led = led_q;

`ifdef QDEC_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if (chg == 2'b11) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Multi-channel quadrature decoder.
// Optional sticky error flags are built only when QDEC_ERR_EN is defined;
// otherwise err is tied to 0.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   A, B       : raw phases, one bit per channel
//   clr        : per-channel synchronous clear
//   EncOut     : packed counters, channel i at [i*CNT_W +: CNT_W]
//   LED        : LED[2i] last step up, LED[2i+1] last step down
//   err        : per-channel sticky illegal-transition flag
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 5,
    parameter int FILT_LEN = 2,
    parameter int WRAP     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       A,
    input  logic [CHANNELS-1:0]       B,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*CNT_W-1:0] EncOut,
    output logic [2*CHANNELS-1:0]     LED,
    output logic [CHANNELS-1:0]       err
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        quad_chan #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN),
            .WRAP     (WRAP)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (A[i]),
            .b     (B[i]),
            .clr   (clr[i]),
            .cnt   (EncOut[i*CNT_W +: CNT_W]),
            .led   (LED[2*i +: 2]),
            .err   (err[i])
        );
    end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] A, B, clr;
    logic [9:0] EncOut, EncOut_s;
    logic [3:0] LED, LED_s;
    logic [1:0] err, err_s;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Expected state: wrapping instance (ew), saturating instance (es).
    logic [4:0] ew [2];
    logic [4:0] es [2];
    logic [1:0] el [2];
    logic [1:0] ee;

    always #5 clk = ~clk;

    quad_decoder #(.CHANNELS(2), .CNT_W(5), .FILT_LEN(2), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr(clr),
        .EncOut(EncOut), .LED(LED), .err(err)
    );

    quad_decoder #(.CHANNELS(2), .CNT_W(5), .FILT_LEN(2), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr(clr),
        .EncOut(EncOut_s), .LED(LED_s), .err(err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"},     32'(EncOut),   32'({ew[1], ew[0]}));
        chk({tag, ".led"},     32'(LED),      32'({el[1], el[0]}));
        chk({tag, ".err"},     32'(err),      32'(ee));
        chk({tag, ".sat_cnt"}, 32'(EncOut_s), 32'({es[1], es[0]}));
        chk({tag, ".sat_led"}, 32'(LED_s),    32'({el[1], el[0]}));
        chk({tag, ".sat_err"}, 32'(err_s),    32'(ee));
    endtask

    task automatic model_up(input int ch);
        ew[ch] = ew[ch] + 5'd1;
        es[ch] = (es[ch] == 5'd31) ? es[ch] : es[ch] + 5'd1;
        el[ch] = 2'b01;
    endtask

    task automatic model_dn(input int ch);
        ew[ch] = ew[ch] - 5'd1;
        es[ch] = (es[ch] == 5'd0) ? es[ch] : es[ch] - 5'd1;
        el[ch] = 2'b10;
    endtask

    task automatic model_err(input int ch);
`ifdef QDEC_ERR_EN
        ee[ch] = 1'b1;
`else
        ee[ch] = 1'b0;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ew[i] = '0; es[i] = '0; el[i] = '0;
        end
        ee = '0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one channel's {A,B} and hold it for 4 clocks.
    task automatic ab(input int ch, input logic [1:0] v);
        A[ch] = v[1];
        B[ch] = v[0];
        settle(4);
    endtask

    task automatic ab2(input logic [1:0] v0, input logic [1:0] v1);
        A = {v1[1], v0[1]};
        B = {v1[0], v0[0]};
        settle(4);
    endtask

    task automatic cw(input int ch);
        ab(ch, 2'b10); ab(ch, 2'b00); ab(ch, 2'b01); ab(ch, 2'b11);
        settle(2);
        model_up(ch);
    endtask

    task automatic ccw(input int ch);
        ab(ch, 2'b01); ab(ch, 2'b00); ab(ch, 2'b10); ab(ch, 2'b11);
        settle(2);
        model_dn(ch);
    endtask

    initial begin
        // Reset with random raw inputs.
        rst_n = 1'b0;
        clr   = 2'b00;
        A     = 2'($urandom);
        B     = 2'($urandom);
        model_reset();
        settle(3);
        chk("rst.cnt", 32'(EncOut), 32'h000);
        chk("rst.led", 32'(LED), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        A = 2'b11;
        B = 2'b11;
        settle(2);
        rst_n = 1'b1;
        settle(2);
        check_all("post_rst");

        // One up step on ch0; ch1 untouched.
        cw(0);
        chk("cw1.ch0", 32'(EncOut[4:0]), 32'd1);
        chk("cw1.led0", 32'(LED[1:0]), 32'b01);
        chk("cw1.ch1", 32'(EncOut[9:5]), 32'd0);
        check_all("cw1");

        // 31 more up steps: wrap to 0, saturating copy holds 31.
        for (int k = 0; k < 31; k++) begin
            cw(0);
            chk("wrap_run", 32'(EncOut[4:0]), 32'(ew[0]));
        end
        chk("wrap.ch0", 32'(EncOut[4:0]), 32'd0);
        chk("sat.ch0", 32'(EncOut_s[4:0]), 32'd31);
        check_all("wrap");

        // Down step on ch1 from 0.
        ccw(1);
        chk("dn.ch1", 32'(EncOut[9:5]), 32'd31);
        chk("dn.led1", 32'(LED[3:2]), 32'b10);
        chk("dn.sat_ch1", 32'(EncOut_s[9:5]), 32'd0);
        chk("dn.sat_led1", 32'(LED_s[3:2]), 32'b10);
        check_all("dn");

        // Single-clock glitch on A is filtered out.
        A[0] = 1'b0;
        settle(1);
        A[0] = 1'b1;
        settle(6);
        check_all("glitch");

        // Start up, back off to detent: no step.
        ab(0, 2'b10); ab(0, 2'b11);
        settle(2);
        check_all("abort");

        // Reversal mid-sequence then completion: exactly one step.
        ab(0, 2'b10); ab(0, 2'b00); ab(0, 2'b10); ab(0, 2'b00);
        ab(0, 2'b01); ab(0, 2'b11);
        settle(2);
        model_up(0);
        check_all("reversal");

        // Illegal 11 -> 00, then recover through detent.
        ab(0, 2'b00);
        model_err(0);
        check_all("illegal_a");
        ab(0, 2'b01); ab(0, 2'b11);
        settle(2);
        check_all("illegal_a_back");
        cw(0);
        check_all("illegal_a_cw");

        // Illegal jump from CW1 holds the FSM until 11: remaining CW
        // phases must not produce a step.
        ab(0, 2'b10); ab(0, 2'b01); ab(0, 2'b00); ab(0, 2'b01); ab(0, 2'b11);
        settle(2);
        model_err(0);
        check_all("illegal_b");

        // Bring ch0 to 7, then clear in the completion cycle of the 8th step.
        repeat (5) cw(0);
        chk("pre_clr.ch0", 32'(EncOut[4:0]), 32'd7);
        ab(0, 2'b10); ab(0, 2'b00); ab(0, 2'b01);
        A[0] = 1'b1;
        B[0] = 1'b1;
        settle(4);
        clr[0] = 1'b1;
        settle(1);
        clr[0] = 1'b0;
        ew[0] = '0; es[0] = '0; el[0] = '0; ee[0] = 1'b0;
        chk("clr.ch0", 32'(EncOut[4:0]), 32'd0);
        chk("clr.led0", 32'(LED[1:0]), 32'b00);
        chk("clr.err0", 32'(err[0]), 32'd0);
        settle(3);
        check_all("clr");

        // Simultaneous up on ch0 and down on ch1.
        ab2(2'b10, 2'b01); ab2(2'b00, 2'b00); ab2(2'b01, 2'b10); ab2(2'b11, 2'b11);
        settle(2);
        model_up(0);
        model_dn(1);
        chk("both.ch0", 32'(EncOut[4:0]), 32'd1);
        chk("both.ch1", 32'(EncOut[9:5]), 32'd30);
        check_all("both");

        // Reset in the middle of an up sequence discards it.
        ab(0, 2'b10); ab(0, 2'b00);
        rst_n = 1'b0;
        A = 2'b11;
        B = 2'b11;
        model_reset();
        settle(2);
        check_all("mid_rst");
        rst_n = 1'b1;
        settle(2);
        ab(0, 2'b01); ab(0, 2'b11);
        settle(2);
        check_all("mid_rst_tail");
        cw(0);
        check_all("mid_rst_cw");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent quadrature knobs.
REQ-002 Parameter CNT_W, default 5, per-channel position counter width.
REQ-003 Parameter FILT_LEN, default 2, consecutive sampled cycles an input must hold before it is accepted (range 1..15).
REQ-004 Parameter WRAP, default 1; 1 = counter wraps modulo 2^CNT_W, 0 = counter saturates at 0 and 2^CNT_W-1.
REQ-005 Port list SHALL be:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  CHANNELS  raw encoder phase A, one bit per channel, asynchronous.
- B  input  CHANNELS  raw encoder phase B, one bit per channel, asynchronous.
- clr  input  CHANNELS  synchronous per-channel counter clear.
- EncOut  output  CHANNELS*CNT_W  packed counters; channel i at [i*CNT_W +: CNT_W].
- LED  output  2*CHANNELS  per channel: LED[2i] = last step up, LED[2i+1] = last step down.
- err  output  CHANNELS  sticky illegal-transition flag.

Function
REQ-006 Each A/B bit SHALL pass through a 2-flop synchroniser, then a filter that updates the filtered bit only after FILT_LEN consecutive identical synchronised samples.
REQ-007 Per-channel FSM on filtered {A,B}: IDLE(11); CW1(10), CW2(00), CW3(01); CCW1(01), CCW2(00), CCW3(10).
REQ-008 Up path: IDLE->CW1->CW2->CW3->IDLE; the return to 11 from CW3 is one up step.
REQ-009 Down path: IDLE->CCW1->CCW2->CCW3->IDLE; the return to 11 from CCW3 is one down step.
REQ-010 Single-bit reversal mid-sequence SHALL step back one state (e.g. CW2->CW1 on 10); a return to 11 from any state other than CW3/CCW3 SHALL produce no step.
REQ-011 A filtered change of both bits in one cycle is illegal: FSM SHALL go to IDLE if the new value is 11, otherwise hold its state until the inputs read 11; no step is produced.
REQ-012 EncOut SHALL update exactly one clk after the cycle the filtered pair returns to 11; the step-to-LED latency SHALL be the same.
REQ-013 Up step at 2^CNT_W-1: WRAP=1 -> 0; WRAP=0 -> hold. Down step at 0: WRAP=1 -> 2^CNT_W-1; WRAP=0 -> hold.
REQ-014 LED pair SHALL be set on every step (up: 01, down: 10) and held until the next step or clr; a saturated step still updates LED.
REQ-015 clr[i] SHALL force counter i to 0 and LED pair i to 00 on the next edge; clr wins over a simultaneous step.
REQ-016 Channels SHALL be fully independent; simultaneous steps on several channels SHALL all be applied.

Reset
REQ-017 While rst_n=0: EncOut=0, LED=0, err=0, FSM=IDLE, synchroniser and filtered bits=1, filter counters=0.
REQ-018 Reset asserted mid-sequence SHALL discard the partial sequence; after release a full sequence is needed for a step.

Configuration
REQ-019 Macro QDEC_ERR_EN defined: err[i] SHALL set on each illegal transition (REQ-011) and clear only on clr[i] or reset.
REQ-020 QDEC_ERR_EN undefined: err SHALL be constant 0 and no error logic is synthesised; REQ-011 FSM recovery is unchanged.

Structure
REQ-021 Package quad_pkg SHALL hold the FSM state typedef, LED bit-index constants (LED_UP=0, LED_DN=1) and the IDLE pattern constant 2'b11.
REQ-022 Sub-module quad_chan (sync, filter, FSM, counter, LED, err for one channel) SHALL be instantiated CHANNELS times by generate.

Verification (CHANNELS=2, CNT_W=5, FILT_LEN=2, each phase held 4 clk)
REQ-023 Assert rst_n=0 with random A/B -> EncOut=10'h000, LED=4'b0000, err=2'b00.
REQ-024 Ch0 {A,B} 11,10,00,01,11 -> EncOut[4:0]=1, LED[1:0]=01; ch1 unchanged; repeat 31 more times -> EncOut[4:0]=0 (WRAP=1).
REQ-025 From 0, ch1 11,01,00,10,11 -> WRAP=1: EncOut[9:5]=31, LED[3:2]=10; WRAP=0: EncOut[9:5]=0, LED[3:2]=10.
REQ-026 Ch0 A pulsed low for 1 clk -> no FSM change, EncOut constant; sequence 11,10,11 -> no step.
REQ-027 Ch0 11 directly to 00 -> err[0]=1 (QDEC_ERR_EN), 0 (undefined); count unchanged; then 11 and a valid CW sequence -> +1.
REQ-028 clr[0] in the completion cycle of an up step with counter 7 -> EncOut[4:0]=0, LED[1:0]=00, err[0]=0.
